// File: rtl/input_pkg.sv
// Shared constants and FSM state type for the front-panel input path.
// Imported by the top-level input_logic module.
package input_pkg;

  localparam int DATA_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT_REL
  } in_state_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low pushbutton.
// Outputs the stable level and a one-cycle pulse on each press.
module key_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic CLK,
  input  logic RESETb,
  input  logic raw_b,
  output logic stable_b,
  output logic fall_pulse
);

  localparam int CW =
    (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   stable_d;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      sync       <= '1;
      cnt        <= '0;
      stable_b   <= 1'b1;
      stable_d   <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], raw_b};
      stable_d   <= stable_b;
      fall_pulse <= stable_d & ~stable_b;
      if (synced == stable_b) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable_b <= ~stable_b;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_logic.sv
// Front-panel input: debounced ENTER captures the switch word,
// offered to the controller through a valid/ack handshake.
module input_logic #(
  parameter int DATA_W       = input_pkg::DATA_W,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic              CLK,
  input  logic              RESETb,
  input  logic [DATA_W-1:0] SW,
  input  logic              KEY_ENTERb,
  input  logic              KEY_PEEKb,
  input  logic              DIN_ACK,
  output logic [DATA_W-1:0] DIN,
  output logic              DIN_VALID,
  output logic              PEEKb,
  output logic              OVR
);

  import input_pkg::*;

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync;
  logic      enter_stable;
  logic      press_evt;
  logic      peek_stable;
  logic      unused_peek_fall;
  in_state_t state;

  key_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_enter (
    .CLK       (CLK),
    .RESETb    (RESETb),
    .raw_b     (KEY_ENTERb),
    .stable_b  (enter_stable),
    .fall_pulse(press_evt)
  );

  key_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_peek (
    .CLK       (CLK),
    .RESETb    (RESETb),
    .raw_b     (KEY_PEEKb),
    .stable_b  (peek_stable),
    .fall_pulse(unused_peek_fall)
  );

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      sw_sync <= '1;
    end else begin
      sw_sync <= {sw_sync[SYNC_STAGES-2:0], SW};
    end
  end

  // Presses arriving outside IDLE are dropped and flagged on OVR.
  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      state     <= IDLE;
      DIN       <= '0;
      DIN_VALID <= 1'b0;
      PEEKb     <= 1'b1;
      OVR       <= 1'b0;
    end else begin
      PEEKb <= peek_stable;
      OVR   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press_evt) begin
            DIN       <= sw_sync[SYNC_STAGES-1];
            DIN_VALID <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (press_evt) OVR <= 1'b1;
          if (DIN_ACK) begin
            DIN_VALID <= 1'b0;
            state     <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (press_evt) OVR <= 1'b1;
          if (enter_stable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_logic.sv
// Scoreboard bench for input_logic with a short debounce interval.
// Expected captures and OVR pulses are queued by stimulus, popped by monitors.
module tb_input_logic;

  localparam int W = 10;

  typedef struct {
    logic [W-1:0] word;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] sw = '0;
  logic         enter = 1'b1;
  logic         peek = 1'b1;
  logic         ack = 1'b0;
  logic [W-1:0] din;
  logic         din_valid;
  logic         peekb;
  logic         ovr;

  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];
  int   ovr_q[$];
  logic prev_valid = 1'b0;

  input_logic #(
    .DATA_W      (W),
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(4)
  ) dut (
    .CLK       (clk),
    .RESETb    (rst_n),
    .SW        (sw),
    .KEY_ENTERb(enter),
    .KEY_PEEKb (peek),
    .DIN_ACK   (ack),
    .DIN       (din),
    .DIN_VALID (din_valid),
    .PEEKb     (peekb),
    .OVR       (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Capture monitor: each rising DIN_VALID must match a queued entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (din_valid && !prev_valid) begin
      chk("valid_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cap_word", int'(din), int'(e.word));
        chk("cap_cycle", cyc, e.cyc);
      end
    end
    prev_valid = din_valid;
    if (ovr) begin
      chk("ovr_expected", int'(ovr_q.size() > 0), 1);
      if (ovr_q.size() > 0) chk("ovr_cycle", cyc, ovr_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [W-1:0] w, input int n);
    sw    = w;
    enter = 1'b0;
    exp_q.push_back('{w, cyc + 8});
    idle(n);
    enter = 1'b1;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_drop", int'(din_valid), 0);
  endtask

  initial begin
    int c;
    bit acked;

    // 1. reset
    rst_n = 1'b0;
    #2;
    chk("rst_din", int'(din), 0);
    chk("rst_valid", int'(din_valid), 0);
    chk("rst_peekb", int'(peekb), 1);
    chk("rst_ovr", int'(ovr), 0);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    chk("post_rst_din", int'(din), 0);
    chk("post_rst_valid", int'(din_valid), 0);
    chk("post_rst_peekb", int'(peekb), 1);
    chk("post_rst_ovr", int'(ovr), 0);

    // 2. clean press and handshake
    sw    = 10'h2A5;
    enter = 1'b0;
    exp_q.push_back('{10'h2A5, cyc + 8});
    acked = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack) begin
        ack = 1'b0;
        chk("t2_ack_drop", int'(din_valid), 0);
      end else if (din_valid && !acked) begin
        chk("t2_din", int'(din), 'h2A5);
        ack   = 1'b1;
        acked = 1;
      end
    end
    enter = 1'b1;
    chk("t2_acked", int'(acked), 1);
    idle(12);
    chk("t2_din_kept", int'(din), 'h2A5);

    // 3. bounce rejection, plus a stray ack in IDLE
    sw    = 10'h3C3;
    enter = 1'b0;
    idle(3);
    enter = 1'b1;
    idle(1);
    enter = 1'b0;
    idle(3);
    enter = 1'b1;
    ack   = 1'b1;
    idle(1);
    ack   = 1'b0;
    idle(12);
    chk("t3_no_valid", int'(din_valid), 0);
    chk("t3_din", int'(din), 'h2A5);

    // 4. overrun while in HOLD
    press(10'h2A5, 8);
    idle(10);
    chk("t4_hold_valid", int'(din_valid), 1);
    c     = cyc;
    ovr_q.push_back(c + 8);
    sw    = 10'h0F0;
    enter = 1'b0;
    idle(8);
    chk("t4_ovr_seen", int'(ovr_q.size()), 0);
    chk("t4_din_kept", int'(din), 'h2A5);
    chk("t4_still_valid", int'(din_valid), 1);
    enter = 1'b1;
    idle(10);
    do_ack();
    idle(4);

    // 4b. press and ack on the same HOLD cycle
    press(10'h155, 8);
    idle(10);
    c     = cyc;
    ovr_q.push_back(c + 8);
    sw    = 10'h3FF;
    enter = 1'b0;
    idle(7);
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    chk("t4b_valid_drop", int'(din_valid), 0);
    chk("t4b_ovr", int'(ovr), 1);
    chk("t4b_din", int'(din), 'h155);
    enter = 1'b1;
    idle(12);

    // 5. async reset in HOLD with key held
    sw    = 10'h1C3;
    enter = 1'b0;
    exp_q.push_back('{10'h1C3, cyc + 8});
    idle(9);
    chk("t5_valid", int'(din_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", int'(din_valid), 0);
    chk("t5_rst_din", int'(din), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{10'h1C3, cyc + 8});
    idle(7);
    chk("t5_no_early", int'(din_valid), 0);
    idle(1);
    chk("t5_recap", int'(din_valid), 1);
    chk("t5_din", int'(din), 'h1C3);
    do_ack();
    enter = 1'b1;
    idle(12);

    // 6. PEEK timing
    peek = 1'b0;
    idle(6);
    chk("t6_peek_early", int'(peekb), 1);
    peek = 1'b1;
    idle(1);
    chk("t6_peek_low", int'(peekb), 0);
    idle(5);
    chk("t6_peek_hold", int'(peekb), 0);
    idle(1);
    chk("t6_peek_rel", int'(peekb), 1);

    // 6b. SW changes after capture do not reach DIN
    press(10'h0AA, 9);
    sw = 10'h355;
    idle(4);
    sw = 10'h000;
    idle(2);
    chk("t6_sw_iso", int'(din), 'h0AA);
    do_ack();
    idle(12);

    chk("exp_drained", exp_q.size(), 0);
    chk("ovr_drained", ovr_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
